// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage RISC-V pipeline: execute-stage forwarding,
// load-use and branch handling, data-memory wait sequencing and perf counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             perf_clr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lu;
    logic       mw;
    logic       run_rules;
    logic       hold_all;
    logic       branch;
    logic       lu_stall;

    // Memory stage wins over writeback because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m,
                                           input logic [4:0] rd_m,
                                           input logic       wr_w,
                                           input logic [4:0] rd_w);
        if (wr_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(RS1_E, RegWriteM, RD_M, RegWriteW, RD_W);
    assign ForwardBE = fwd_sel(RS2_E, RegWriteM, RD_M, RegWriteW, RD_W);

    assign lu = ResultSrcE && RD_E != 5'd0 && (RD_E == RS1_D || RD_E == RS2_D);
    assign mw = MemReqM && !MemReadyM;

    // The release cycle of a memory wait applies the RUN rules directly (Mealy).
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        run_rules = 1'b0;
        hold_all  = 1'b0;
        case (state)
            RUN:      run_rules = 1'b1;
            MEM_WAIT: if (MemReadyM) run_rules = 1'b1; else hold_all = 1'b1;
            default:  hold_all = 1'b1;
        endcase
        if (run_rules && mw)
            hold_all = 1'b1;
        branch   = run_rules && !mw && PCSrcE;
        lu_stall = run_rules && !mw && !PCSrcE && lu;
    end

    assign StallF = rst && (hold_all || lu_stall);
    assign StallD = rst && (hold_all || lu_stall);
    assign StallE = rst && hold_all;
    assign StallM = rst && hold_all;
    assign FlushD = rst && branch;
    assign FlushE = rst && (branch || lu_stall);
    assign FlushW = rst && hold_all;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mw) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
                            state   <= HALT;
                            mem_err <= 1'b1;
                        end
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    // Only branch-caused squashes count as flushes; load-use bubbles do not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (FlushD && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage RISC-V pipeline (fetch, decode, execute, memory, writeback).
- Produces operand-forwarding selects for the execute stage, and stall/flush strobes for the pipeline registers.
- Sequences data-memory wait states through a small FSM, with a timeout and a sticky error.
- Keeps saturating stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive memory-wait cycles before the error condition; legal range 2..255.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- RS1_D, RS2_D  in  5  source registers of the instruction in decode
- RS1_E, RS2_E, RD_E  in  5  source and destination registers in execute
- RD_M, RD_W  in  5  destination registers in memory and writeback
- RegWriteM, RegWriteW  in  1  register-write enables in memory and writeback
- ResultSrcE  in  1  execute-stage instruction is a load
- PCSrcE  in  1  branch taken / redirect resolved in execute
- MemReqM  in  1  data-memory access active in the memory stage
- MemReadyM  in  1  data memory completes the access this cycle
- perf_clr  in  1  synchronous clear of the performance counters
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  load a bubble into the corresponding pipeline register
- mem_err  out  1  sticky memory-timeout error
- stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; wait counter=0; mem_err=0; stall_cnt=0; flush_cnt=0.
  - All stall and flush outputs are forced to 0 while reset is asserted.
- Forwarding (combinational, independent of state), shown for operand A; operand B is identical using RS2_E:
  - 10 if RegWriteM and RD_M!=0 and RD_M==RS1_E;
  - else 01 if RegWriteW and RD_W!=0 and RD_W==RS1_E;
  - else 00.
  - The memory stage has priority over writeback.
- Hazard terms (combinational):
  - lu = ResultSrcE and RD_E!=0 and (RD_E==RS1_D or RD_E==RS2_D)
  - mw = MemReqM and not MemReadyM
- FSM states: RUN, MEM_WAIT, HALT.
- RUN outputs, evaluated in priority order:
  - If mw: StallF=StallD=StallE=StallM=1, FlushW=1, no other flush; next state MEM_WAIT; wait counter←1.
  - Else if PCSrcE: FlushD=FlushE=1, no stalls. A branch overrides a simultaneous load-use stall, because the dependent instruction is squashed.
  - Else if lu: StallF=StallD=1, FlushE=1.
  - Otherwise all stall and flush outputs are 0.
- MEM_WAIT:
  - While MemReadyM=0: all four stalls =1, FlushW=1, wait counter increments.
  - If the counter would reach MEM_TIMEOUT with MemReadyM still 0: next state HALT, mem_err←1.
  - When MemReadyM=1: outputs follow the RUN rules for that same cycle (Mealy, so the release is zero-latency); next state RUN; wait counter←0.
  - A PCSrcE held in execute during the wait is acted on in the release cycle.
- HALT:
  - All four stalls =1 and FlushW=1 permanently. Only reset exits HALT.
  - mem_err stays 1 until reset.
- Counters (registered, saturating at all-ones, no wrap):
  - stall_cnt +1 on every cycle with StallF=1.
  - flush_cnt +1 on every cycle with FlushE=1 caused by PCSrcE. Load-use bubbles are not counted in flush_cnt.
  - perf_clr clears both counters and wins over a same-cycle increment; it does not affect state or mem_err.
- Reset asserted mid-wait returns the block to RUN immediately with no residual stall.
- Register x0 never produces forwarding or load-use hazards.

Test Plan:
- Forwarding priority: RegWriteM=RegWriteW=1, RD_M=RD_W=RS1_E=5 -> ForwardAE=10. With RD_M=0 and RD_W=5 -> ForwardAE=01. RS1_E=0 with any RD -> 00.
- Load-use: ResultSrcE=1, RD_E=7, RS2_D=7 -> StallF=StallD=FlushE=1 for exactly one cycle, stall_cnt +1. Same case with RD_E=0 -> no stall.
- Branch plus load-use in the same cycle: PCSrcE=1, lu true -> FlushD=FlushE=1, StallF=0, flush_cnt +1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all stalls and FlushW high for 3 cycles, released in the 4th, state back to RUN, stall_cnt +3.
- Timeout: MEM_TIMEOUT=4, MemReadyM held at 0 -> HALT with mem_err=1 after 4 wait cycles; stalls stay high; rst low clears mem_err and all stalls asynchronously.
- Counters: force stall_cnt to saturate with CNT_W=4 -> holds at 15. perf_clr pulsed together with a stall -> stall_cnt=0.
